bus_arbiter: RTL

//  Shares the single memory port between instruction fetch (ibus) and the load/store path (dbus, driven by cu_t dbus_re/dbus_we).

---
 rtl/bus_arbiter_if.sv | 44 ++++
 rtl/bus_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_if.sv
// Core/memory signal bundle around the bus arbiter; the arbiter takes the slave view,
// the core+memory environment the master view.
interface bus_arbiter_if;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic [31:0] ibus_rdata;
    logic        ibus_ack;
    logic        ibus_err;

    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_rdata;
    logic        dbus_ack;
    logic        dbus_err;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport slave (
        input  ibus_req, ibus_addr,
        output ibus_rdata, ibus_ack, ibus_err,
        input  dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be,
        output dbus_rdata, dbus_ack, dbus_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata, mem_ack
    );

    modport master (
        output ibus_req, ibus_addr,
        input  ibus_rdata, ibus_ack, ibus_err,
        output dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be,
        input  dbus_rdata, dbus_ack, dbus_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/bus_arbiter.sv
// Shares one memory port between fetch (ibus) and load/store (dbus); dbus wins unless ibus has waited MAX_D_STREAK grants.
// Latency: req in IDLE -> mem_req next cycle, mem_ack -> x_ack next cycle; requesters hold req until ack, watchdog aborts after TIMEOUT.
module bus_arbiter #(
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic         clk,
    input  logic         reset,
    bus_arbiter_if.slave bus
);
    localparam int              SW         = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_D_STREAK);
    localparam logic [7:0]      WD_LAST    = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RESP} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [7:0]    wd_q, wd_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic [31:0]   ibus_rdata_q, ibus_rdata_d;
    logic          ibus_ack_q, ibus_ack_d;
    logic          ibus_err_q, ibus_err_d;
    logic [31:0]   dbus_rdata_q, dbus_rdata_d;
    logic          dbus_ack_q, dbus_ack_d;
    logic          dbus_err_q, dbus_err_d;
    logic          fetch_starved;

    assign fetch_starved = bus.ibus_req && (streak_q == STREAK_MAX);

    always_comb begin
        state_d      = state_q;
        streak_d     = streak_q;
        wd_d         = wd_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        ibus_rdata_d = ibus_rdata_q;
        dbus_rdata_d = dbus_rdata_q;
        ibus_ack_d   = 1'b0;
        ibus_err_d   = 1'b0;
        dbus_ack_d   = 1'b0;
        dbus_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!bus.ibus_req) streak_d = '0;
                if (bus.dbus_req && !fetch_starved) begin
                    state_d     = GRANT_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.dbus_we;
                    mem_addr_d  = bus.dbus_addr;
                    mem_wdata_d = bus.dbus_wdata;
                    mem_be_d    = bus.dbus_be;
                    wd_d        = '0;
                    // Saturates by construction: at STREAK_MAX a waiting fetch takes the grant.
                    if (bus.ibus_req) streak_d = streak_q + 1'b1;
                end else if (bus.ibus_req) begin
                    state_d     = GRANT_I;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.ibus_addr;
                    mem_wdata_d = '0;
                    mem_be_d    = 4'hF;
                    wd_d        = '0;
                    streak_d    = '0;
                end
            end
            GRANT_I, GRANT_D: begin
                if (bus.mem_ack) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    if (state_q == GRANT_D) begin
                        dbus_ack_d   = 1'b1;
                        dbus_rdata_d = bus.mem_rdata;
                    end else begin
                        ibus_ack_d   = 1'b1;
                        ibus_rdata_d = bus.mem_rdata;
                    end
                end else if (wd_q == WD_LAST) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    if (state_q == GRANT_D) begin
                        dbus_ack_d = 1'b1;
                        dbus_err_d = 1'b1;
                    end else begin
                        ibus_ack_d = 1'b1;
                        ibus_err_d = 1'b1;
                    end
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            streak_q     <= '0;
            wd_q         <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            ibus_rdata_q <= '0;
            ibus_ack_q   <= 1'b0;
            ibus_err_q   <= 1'b0;
            dbus_rdata_q <= '0;
            dbus_ack_q   <= 1'b0;
            dbus_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            streak_q     <= streak_d;
            wd_q         <= wd_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            ibus_rdata_q <= ibus_rdata_d;
            ibus_ack_q   <= ibus_ack_d;
            ibus_err_q   <= ibus_err_d;
            dbus_rdata_q <= dbus_rdata_d;
            dbus_ack_q   <= dbus_ack_d;
            dbus_err_q   <= dbus_err_d;
        end
    end

    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_be     = mem_be_q;
    assign bus.ibus_rdata = ibus_rdata_q;
    assign bus.ibus_ack   = ibus_ack_q;
    assign bus.ibus_err   = ibus_err_q;
    assign bus.dbus_rdata = dbus_rdata_q;
    assign bus.dbus_ack   = dbus_ack_q;
    assign bus.dbus_err   = dbus_err_q;
endmodule
